// File: rtl/pxconv_pkg.sv
// ==== pxconv_pkg : shared types, coefficients and helpers for the pixel ring ====
// ==== rev 1.0 ====
`default_nettype none

package pxconv_pkg;

  typedef enum logic [1:0] {
    ST_FILL   = 2'd0,
    ST_STEADY = 2'd1,
    ST_DRAIN  = 2'd2
  } state_t;

  localparam int c_LUMA_R = 77;
  localparam int c_LUMA_G = 150;
  localparam int c_LUMA_B = 29;

  localparam int c_MODE_AVG  = 0;
  localparam int c_MODE_LUMA = 1;

  // Never returns 0 so that degenerate counters still get a 1-bit register.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/pxconv_ring_if.sv
// ==== pxconv_ring_if : pixel/BRAM/status bundle of the pixel ring ====
// ==== rev 1.0 ====
`default_nettype none

interface pxconv_ring_if #(
  parameter int IN_W   = 16,
  parameter int OUT_W  = 8,
  parameter int ADDR_W = 5
);
  logic [IN_W-1:0]   in_data;
  logic              in_valid;
  logic              line_ack;
  logic              rd_req;
  logic [11:0]       mst_length;
  logic              bram_we;
  logic [ADDR_W-1:0] bram_addr;
  logic [OUT_W-1:0]  bram_data;
  logic              busy;
  logic              wnd_valid;
  logic              frame_done;
  logic              err_ovf;
  logic              err_ack;

  modport master (
    output in_data, in_valid, line_ack,
    input  rd_req, mst_length, bram_we, bram_addr, bram_data,
    input  busy, wnd_valid, frame_done, err_ovf, err_ack
  );

  modport slave (
    input  in_data, in_valid, line_ack,
    output rd_req, mst_length, bram_we, bram_addr, bram_data,
    output busy, wnd_valid, frame_done, err_ovf, err_ack
  );
endinterface

`default_nettype wire

// File: rtl/px2grey.sv
// ==== px2grey : combinational RGB565/RGB888 to grey (average or BT.601 luma) ====
// ==== rev 1.0 ====
`default_nettype none

module px2grey
  import pxconv_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int OUT_W = 8,
  parameter int MODE  = 0
) (
  input  wire logic [IN_W-1:0]  i_px,
  output logic      [OUT_W-1:0] o_grey
);

  logic [7:0] w_r;
  logic [7:0] w_g;
  logic [7:0] w_b;
  logic [7:0] w_grey8;

  generate
    if (IN_W == 16) begin : g_rgb565
      assign w_r = {i_px[15:11], 3'b000};
      assign w_g = {i_px[10:5],  2'b00};
      assign w_b = {i_px[4:0],   3'b000};
    end else begin : g_rgb888
      assign w_r = i_px[23:16];
      assign w_g = i_px[15:8];
      assign w_b = i_px[7:0];
    end

    // Full-width sums; the only narrowing happens after the divide/shift.
    if (MODE == c_MODE_LUMA) begin : g_luma
      logic [15:0] w_sum;
      assign w_sum   = 16'(c_LUMA_R) * {8'h00, w_r}
                     + 16'(c_LUMA_G) * {8'h00, w_g}
                     + 16'(c_LUMA_B) * {8'h00, w_b};
      assign w_grey8 = 8'(w_sum >> 8);
    end else begin : g_avg
      logic [9:0] w_sum;
      assign w_sum   = {2'b00, w_r} + {2'b00, w_g} + {2'b00, w_b};
      assign w_grey8 = 8'(w_sum / 10'd3);
    end

    if (OUT_W <= 8) begin : g_out_narrow
      assign o_grey = OUT_W'(w_grey8 >> (8 - OUT_W));
    end else begin : g_out_wide
      assign o_grey = {w_grey8, {(OUT_W-8){1'b0}}};
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/pxconv_ring.sv
// ==== pxconv_ring : grey conversion into an NLINES line ring with credit throttling ====
// ==== rev 1.0 ====
`default_nettype none

module pxconv_ring
  import pxconv_pkg::*;
#(
  parameter int HRES   = 640,
  parameter int VRES   = 480,
  parameter int WINDOW = 7,
  parameter int NLINES = 8,
  parameter int BURST  = 128,
  parameter int IN_W   = 16,
  parameter int OUT_W  = 8,
  parameter int MODE   = 0
) (
  input  wire logic     clk,
  input  wire logic     rst_n,
  pxconv_ring_if.slave  bus
);

  localparam int c_PX     = BURST / (IN_W / 8);
  localparam int c_BPL    = HRES / c_PX;
  localparam int c_RING   = NLINES * HRES;
  localparam int c_ADDR_W = clog2(c_RING);
  localparam int c_ACKS   = VRES - WINDOW + 1;
  localparam int c_BEAT_W = clog2(c_PX);
  localparam int c_BRST_W = clog2(c_BPL);
  localparam int c_ROW_W  = clog2(VRES);
  localparam int c_HELD_W = clog2(NLINES + 1);
  localparam int c_ACK_W  = clog2(c_ACKS);

  localparam logic [c_ADDR_W-1:0] c_ADDR_LAST  = c_ADDR_W'(c_RING - 1);
  localparam logic [c_BEAT_W-1:0] c_BEAT_LAST  = c_BEAT_W'(c_PX - 1);
  localparam logic [c_BRST_W-1:0] c_BRST_LAST  = c_BRST_W'(c_BPL - 1);
  localparam logic [c_ROW_W-1:0]  c_ROW_LAST   = c_ROW_W'(VRES - 1);
  localparam logic [c_ACK_W-1:0]  c_ACK_LAST   = c_ACK_W'(c_ACKS - 1);
  localparam logic [c_HELD_W-1:0] c_HELD_SPACE = c_HELD_W'(NLINES - 1);
  localparam logic [c_HELD_W-1:0] c_HELD_WIN   = c_HELD_W'(WINDOW);

  // ---------------- conversion pipeline ----------------
  logic                r_s1_valid;
  logic [IN_W-1:0]     r_s1_data;
  logic                r_we;
  logic [OUT_W-1:0]    r_data;
  logic [c_ADDR_W-1:0] r_addr;
  logic [OUT_W-1:0]    w_grey;

  // ---------------- control ----------------
  state_t              r_state;
  logic                r_out;
  logic [c_BEAT_W-1:0] r_beat;
  logic [c_BRST_W-1:0] r_burst;
  logic [c_ROW_W-1:0]  r_row;
  logic [c_HELD_W-1:0] r_held;
  logic [c_ACK_W-1:0]  r_ack;
  logic                r_rd_req;
  logic                r_wnd;
  logic                r_done;
  logic                r_err_ovf;
  logic                r_err_ack;

  logic                w_first;
  logic                w_beat;
  logic                w_drop;
  logic                w_last;
  logic                w_line_done;
  logic                w_row_wrap;
  logic                w_ack_ok;
  logic                w_flush;
  logic                w_out_nxt;
  logic                w_drain_nxt;
  logic                w_space;
  logic [c_BRST_W-1:0] w_burst_nxt;
  logic [c_HELD_W-1:0] w_held_nxt;

  px2grey #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W),
    .MODE  (MODE)
  ) u_px2grey (
    .i_px   (r_s1_data),
    .o_grey (w_grey)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_data  <= '0;
      r_we       <= 1'b0;
      r_data     <= '0;
      r_addr     <= c_ADDR_LAST;
    end else begin
      r_s1_valid <= w_beat;
      r_s1_data  <= bus.in_data;
      r_we       <= r_s1_valid;
      if (r_s1_valid) r_data <= w_grey;
      if (w_flush)
        r_addr <= c_ADDR_LAST;
      else if (r_s1_valid)
        r_addr <= (r_addr == c_ADDR_LAST) ? '0 : r_addr + 1'b1;
    end
  end

  // A beat is taken when a burst is outstanding or rd_req invites a new one.
  assign w_first     = bus.in_valid & ~r_out & r_rd_req;
  assign w_beat      = bus.in_valid & (r_out | r_rd_req);
  assign w_drop      = bus.in_valid & ~r_out & ~r_rd_req;
  assign w_last      = w_beat & (r_beat == c_BEAT_LAST);
  assign w_line_done = w_last & (r_burst == c_BRST_LAST);
  assign w_row_wrap  = w_line_done & (r_row == c_ROW_LAST);
  assign w_ack_ok    = bus.line_ack & (r_held != '0);
  assign w_flush     = (r_state == ST_DRAIN) & w_ack_ok & (r_ack == c_ACK_LAST);

  assign w_out_nxt   = w_last ? 1'b0 : (w_first ? 1'b1 : r_out);
  assign w_burst_nxt = w_last ? ((r_burst == c_BRST_LAST) ? '0 : r_burst + 1'b1) : r_burst;
  assign w_drain_nxt = ((r_state == ST_DRAIN) & ~w_flush) | ((r_state == ST_STEADY) & w_row_wrap);
  assign w_space     = (w_burst_nxt != '0) | (w_held_nxt < c_HELD_SPACE);

  always_comb begin
    w_held_nxt = r_held;
    if (w_line_done && !w_ack_ok)
      w_held_nxt = r_held + 1'b1;
    else if (!w_line_done && w_ack_ok)
      w_held_nxt = r_held - 1'b1;
    if (w_flush)
      w_held_nxt = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_FILL;
      r_out     <= 1'b0;
      r_beat    <= '0;
      r_burst   <= '0;
      r_row     <= '0;
      r_held    <= '0;
      r_ack     <= '0;
      r_rd_req  <= 1'b0;
      r_wnd     <= 1'b0;
      r_done    <= 1'b0;
      r_err_ovf <= 1'b0;
      r_err_ack <= 1'b0;
    end else begin
      r_out   <= w_out_nxt;
      r_burst <= w_burst_nxt;
      r_held  <= w_held_nxt;
      if (w_beat)
        r_beat <= w_last ? '0 : r_beat + 1'b1;
      if (w_line_done)
        r_row <= (r_row == c_ROW_LAST) ? '0 : r_row + 1'b1;
      if (w_flush)
        r_ack <= '0;
      else if (w_ack_ok)
        r_ack <= (r_ack == c_ACK_LAST) ? '0 : r_ack + 1'b1;

      r_rd_req <= ~w_drain_nxt & ~w_out_nxt & w_space;
      r_wnd    <= ~w_flush & (w_held_nxt >= c_HELD_WIN);
      r_done   <= w_flush;
      if (w_drop)
        r_err_ovf <= 1'b1;
      if (bus.line_ack && (r_held == '0))
        r_err_ack <= 1'b1;

      case (r_state)
        ST_FILL:   if (w_held_nxt >= c_HELD_WIN) r_state <= ST_STEADY;
        ST_STEADY: if (w_row_wrap)               r_state <= ST_DRAIN;
        ST_DRAIN:  if (w_flush)                  r_state <= ST_FILL;
        default:                                 r_state <= ST_FILL;
      endcase
    end
  end

  assign bus.rd_req     = r_rd_req;
  assign bus.mst_length = 12'(BURST);
  assign bus.bram_we    = r_we;
  assign bus.bram_addr  = r_addr;
  assign bus.bram_data  = r_data;
  assign bus.busy       = r_we;
  assign bus.wnd_valid  = r_wnd;
  assign bus.frame_done = r_done;
  assign bus.err_ovf    = r_err_ovf;
  assign bus.err_ack    = r_err_ack;

endmodule

`default_nettype wire

// File: tb/tb_pxconv_ring.sv
// ==== tb_pxconv_ring : directed bench for the pixel ring (8x6 frame, 4-line ring) ====
// ==== rev 1.0 ====
`default_nettype none

module tb_pxconv_ring;

  localparam int HRES   = 8;
  localparam int VRES   = 6;
  localparam int WINDOW = 3;
  localparam int NLINES = 4;
  localparam int BURST  = 8;
  localparam int IN_W   = 16;
  localparam int OUT_W  = 8;
  localparam int MODE   = 0;
  localparam int ADDR_W = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pxconv_ring_if #(.IN_W(IN_W), .OUT_W(OUT_W), .ADDR_W(ADDR_W)) bus ();

  pxconv_ring #(
    .HRES(HRES), .VRES(VRES), .WINDOW(WINDOW), .NLINES(NLINES),
    .BURST(BURST), .IN_W(IN_W), .OUT_W(OUT_W), .MODE(MODE)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [15:0] luma_px;
  logic [7:0]  luma_out;
  logic [23:0] px888;
  logic [7:0]  px888_out;

  px2grey #(.IN_W(16), .OUT_W(8), .MODE(1)) u_luma   (.i_px(luma_px), .o_grey(luma_out));
  px2grey #(.IN_W(24), .OUT_W(8), .MODE(0)) u_rgb888 (.i_px(px888),   .o_grey(px888_out));

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int first_cyc = 0;
  int lat0     = 0;

  typedef struct {
    int addr;
    int data;
    int cyc;
  } wr_t;
  wr_t wlog[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk)
    if (rst_n && bus.bram_we)
      wlog.push_back('{int'(bus.bram_addr), int'(bus.bram_data), cyc});

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic wr_t wr_at(input int idx);
    wr_t none;
    none = '{-1, -1, -1};
    if (idx < wlog.size()) return wlog[idx];
    return none;
  endfunction

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_burst(input logic [15:0] p0, input logic [15:0] p1,
                            input logic [15:0] p2, input logic [15:0] p3,
                            input bit ack_last);
    logic [15:0] px [4];
    int w;
    px = '{p0, p1, p2, p3};
    w = 0;
    @(negedge clk);
    while (bus.rd_req !== 1'b1 && w < 50) begin
      @(negedge clk);
      w++;
    end
    check("rdreq_wait", 32'(bus.rd_req), 1);
    if (bus.rd_req !== 1'b1) return;
    for (int i = 0; i < 4; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = px[i];
      bus.line_ack = ack_last && (i == 3);
      @(negedge clk);
      if (i == 0) begin
        first_cyc = cyc;
        check("rdreq_drop", 32'(bus.rd_req), 0);
      end
    end
    bus.in_valid = 1'b0;
    bus.line_ack = 1'b0;
    bus.in_data  = '0;
  endtask

  task automatic send_line(input logic [15:0] p, input bit ack_last);
    send_burst(p, p, p, p, 1'b0);
    send_burst(p, p, p, p, ack_last);
  endtask

  task automatic pulse_ack();
    bus.line_ack = 1'b1;
    @(negedge clk);
    bus.line_ack = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.line_ack = 1'b0;
    luma_px = 16'h0000;
    px888   = 24'h000000;
    wait_cyc(3);

    check("rst_rd_req",     32'(bus.rd_req),     0);
    check("rst_mst_length", 32'(bus.mst_length), 8);
    check("rst_bram_we",    32'(bus.bram_we),    0);
    check("rst_bram_addr",  32'(bus.bram_addr),  31);
    check("rst_bram_data",  32'(bus.bram_data),  0);
    check("rst_busy",       32'(bus.busy),       0);
    check("rst_wnd_valid",  32'(bus.wnd_valid),  0);
    check("rst_frame_done", 32'(bus.frame_done), 0);
    check("rst_err_ovf",    32'(bus.err_ovf),    0);
    check("rst_err_ack",    32'(bus.err_ack),    0);

    // Luma: white gives (77*248+150*252+29*248)>>8 = 250.
    luma_px = 16'hFFFF; #1 check("luma_white", 32'(luma_out), 32'hFA);
    luma_px = 16'hF800; #1 check("luma_red",   32'(luma_out), 32'h4A);
    luma_px = 16'h07E0; #1 check("luma_green", 32'(luma_out), 32'h93);
    luma_px = 16'h001F; #1 check("luma_blue",  32'(luma_out), 32'h1C);
    px888   = 24'h306090; #1 check("avg_rgb888", 32'(px888_out), 32'h60);

    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rdreq_after_rst", 32'(bus.rd_req), 1);

    // Line 1: white averages to 249 because green zero-fills to 0xFC.
    send_burst(16'hFFFF, 16'hF800, 16'h07E0, 16'h001F, 1'b0);
    lat0 = first_cyc;
    check("busy_writing", 32'(bus.busy), 1);
    send_burst(16'h0841, 16'h0841, 16'h0841, 16'h0841, 1'b0);
    wait_cyc(3);
    check("l1_count",  32'(wlog.size()), 8);
    check("l1_addr0",  32'(wr_at(0).addr), 0);
    check("l1_data0",  32'(wr_at(0).data), 32'hF9);
    check("l1_lat",    32'(wr_at(0).cyc),  32'(lat0 + 1));
    check("l1_data1",  32'(wr_at(1).data), 32'h52);
    check("l1_data2",  32'(wr_at(2).data), 32'h54);
    check("l1_data3",  32'(wr_at(3).data), 32'h52);
    check("l1_addr7",  32'(wr_at(7).addr), 7);
    check("l1_data7",  32'(wr_at(7).data), 32'h08);

    send_line(16'h8410, 1'b0);
    wait_cyc(3);
    check("l2_data8",  32'(wr_at(8).data), 32'h80);
    check("l2_addr8",  32'(wr_at(8).addr), 8);
    check("l2_wnd",    32'(bus.wnd_valid), 0);
    check("l2_rdreq",  32'(bus.rd_req),    1);

    send_line(16'h0000, 1'b0);
    wait_cyc(3);
    check("l3_rdreq_full", 32'(bus.rd_req),    0);
    check("l3_wnd",        32'(bus.wnd_valid), 1);
    check("l3_count",      32'(wlog.size()),   24);
    check("l3_last_addr",  32'(wr_at(23).addr), 23);

    bus.in_valid = 1'b1;
    bus.in_data  = 16'hFFFF;
    @(negedge clk);
    bus.in_valid = 1'b0;
    wait_cyc(3);
    check("ovf_flag",  32'(bus.err_ovf),  1);
    check("ovf_nowr",  32'(wlog.size()),  24);

    pulse_ack();
    check("ack1_rdreq", 32'(bus.rd_req),    1);
    check("ack1_wnd",   32'(bus.wnd_valid), 0);

    send_line(16'h0841, 1'b0);
    wait_cyc(3);
    check("l4_addr24", 32'(wr_at(24).addr), 24);
    check("l4_addr31", 32'(wr_at(31).addr), 31);
    check("l4_rdreq",  32'(bus.rd_req),     0);

    pulse_ack();
    send_burst(16'h0841, 16'h0841, 16'h0841, 16'h0841, 1'b0);
    send_burst(16'h0841, 16'h0841, 16'h0841, 16'h0841, 1'b1);
    wait_cyc(3);
    check("l5_wrap_addr",   32'(wr_at(32).addr), 0);
    check("coinc_rdreq",    32'(bus.rd_req),     1);
    check("coinc_wnd",      32'(bus.wnd_valid),  0);

    send_line(16'h0841, 1'b0);
    wait_cyc(3);
    check("drain_rdreq", 32'(bus.rd_req),     0);
    check("drain_wnd",   32'(bus.wnd_valid),  1);
    check("drain_count", 32'(wlog.size()),    48);
    check("drain_done0", 32'(bus.frame_done), 0);

    pulse_ack();
    check("flush_done",  32'(bus.frame_done), 1);
    check("flush_wnd",   32'(bus.wnd_valid),  0);
    @(negedge clk);
    check("done_pulse",  32'(bus.frame_done), 0);
    check("fill_rdreq",  32'(bus.rd_req),     1);

    pulse_ack();
    check("ack_err",     32'(bus.err_ack),    1);

    send_burst(16'hF800, 16'hF800, 16'hF800, 16'hF800, 1'b0);
    wait_cyc(3);
    check("f2_addr0",    32'(wr_at(48).addr), 0);
    check("f2_data0",    32'(wr_at(48).data), 32'h52);

    // Two beats of a new burst, then reset between clock edges.
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = 16'hFFFF;
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_bram_we",   32'(bus.bram_we),   0);
    check("arst_bram_addr", 32'(bus.bram_addr), 31);
    check("arst_rd_req",    32'(bus.rd_req),    0);
    check("arst_err_ovf",   32'(bus.err_ovf),   0);
    check("arst_err_ack",   32'(bus.err_ack),   0);
    check("arst_busy",      32'(bus.busy),      0);
    bus.in_valid = 1'b0;
    wait_cyc(2);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
